mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter over a byte-serial RAM port; one transaction at a time.
// Read N bytes completes N+2 cycles after grant, write N bytes N+1; rdy_in low freezes, I/O full stalls stores.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        ls_req,
    input  logic [31:0] ls_addr,
    input  logic        ls_r_nw,
    input  logic [2:0]  ls_type,
    input  logic [31:0] st_val,
    output logic [31:0] ld_val,
    output logic        ls_done,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [2:0]  nb_q, nb_d;
    logic        sgn_q, sgn_d;
    logic [31:0] st_q, st_d;
    logic        own_ls_q, own_ls_d;
    logic        last_ls_q, last_ls_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ld_val_q, ld_val_d;

    logic        grant_if, grant_ls, pick_ls, io_stall;
    logic [2:0]  ls_nb;
    logic [31:0] ext_data;

    always_comb begin
        grant_if = if_req && !flush;
        grant_ls = ls_req;
        // On contention LS wins unless it won last time.
        pick_ls  = grant_ls && (!grant_if || !last_ls_q);
        io_stall = io_buffer_full && (base_q >= IO_BASE);
        case (ls_type[1:0])
            2'b01:   ls_nb = 3'd2;
            2'b10:   ls_nb = 3'd1;
            default: ls_nb = 3'd4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nb_d      = nb_q;
        sgn_d     = sgn_q;
        st_d      = st_q;
        own_ls_d  = own_ls_q;
        last_ls_d = last_ls_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        if_data_d = if_data_q;
        ld_val_d  = ld_val_q;
        ext_data  = 32'd0;

        case (state_q)
            IDLE: begin
                if (grant_if || grant_ls) begin
                    own_ls_d  = pick_ls;
                    last_ls_d = pick_ls;
                    cnt_d     = 3'd0;
                    data_d    = 32'd0;
                    if (pick_ls) begin
                        base_d  = ls_addr;
                        nb_d    = ls_nb;
                        sgn_d   = ls_type[2];
                        st_d    = st_val;
                        state_d = ls_r_nw ? READ : WRITE;
                    end else begin
                        base_d  = if_addr;
                        nb_d    = 3'd4;
                        sgn_d   = 1'b0;
                        st_d    = 32'd0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (!own_ls_q && flush) begin
                    state_d = IDLE;
                end else begin
                    // Byte k-1 arrives on mem_din while the counter reads k.
                    case (cnt_q)
                        3'd1:    data_d[7:0]   = mem_din;
                        3'd2:    data_d[15:8]  = mem_din;
                        3'd3:    data_d[23:16] = mem_din;
                        3'd4:    data_d[31:24] = mem_din;
                        default: ;
                    endcase
                    case (nb_q)
                        3'd1:    ext_data = sgn_q ? {{24{data_d[7]}}, data_d[7:0]}
                                                  : {24'd0, data_d[7:0]};
                        3'd2:    ext_data = sgn_q ? {{16{data_d[15]}}, data_d[15:0]}
                                                  : {16'd0, data_d[15:0]};
                        default: ext_data = data_d;
                    endcase
                    if (cnt_q == nb_q) begin
                        state_d = DONE;
                        if (own_ls_q) ld_val_d  = ext_data;
                        else          if_data_d = data_d;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            WRITE: begin
                if (!io_stall) begin
                    if (cnt_q == nb_q - 3'd1) begin
                        state_d  = DONE;
                        ld_val_d = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            base_q    <= 32'd0;
            nb_q      <= 3'd0;
            sgn_q     <= 1'b0;
            st_q      <= 32'd0;
            own_ls_q  <= 1'b0;
            last_ls_q <= 1'b0;
            cnt_q     <= 3'd0;
            data_q    <= 32'd0;
            if_data_q <= 32'd0;
            ld_val_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            base_q    <= base_d;
            nb_q      <= nb_d;
            sgn_q     <= sgn_d;
            st_q      <= st_d;
            own_ls_q  <= own_ls_d;
            last_ls_q <= last_ls_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            if_data_q <= if_data_d;
            ld_val_q  <= ld_val_d;
        end
    end

    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        if (state_q == READ || state_q == WRITE) mem_a = base_q + {29'd0, cnt_q};
        if (state_q == WRITE) begin
            case (cnt_q[1:0])
                2'd0: mem_dout = st_q[7:0];
                2'd1: mem_dout = st_q[15:8];
                2'd2: mem_dout = st_q[23:16];
                2'd3: mem_dout = st_q[31:24];
                default: mem_dout = 8'd0;
            endcase
        end
        mem_wr  = (state_q == WRITE) && rdy_in && !io_stall;
        if_done = (state_q == DONE) && !own_ls_q;
        ls_done = (state_q == DONE) && own_ls_q;
        if_data = if_data_q;
        ld_val  = ld_val_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a byte RAM that registers mem_din from mem_a each clock.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_r_nw, ls_done;
    logic [31:0] ls_addr, st_val, ld_val;
    logic [2:0]  ls_type;
    logic        flush, mem_wr, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;

    logic [7:0]  ram [0:4095];
    logic [31:0] wr_a [0:15];
    logic [7:0]  wr_d [0:15];
    int          wr_n;
    int          total = 0;
    int          bad = 0;
    int          n;

    mem_arbiter #(.IO_BASE(32'h00030000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_r_nw(ls_r_nw), .ls_type(ls_type),
        .st_val(st_val), .ld_val(ld_val), .ls_done(ls_done), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
            if (wr_n < 16) begin
                wr_a[wr_n] = mem_a;
                wr_d[wr_n] = mem_dout;
            end
            wr_n = wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit is_if, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(is_if ? if_done : ls_done) && cyc < 30);
        if (!(is_if ? if_done : ls_done)) cyc = -1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_addr = 32'd0;
        ls_r_nw = 1'b1; ls_type = 3'd0; st_val = 32'd0; wr_n = 0; mem_din = 8'd0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'd0;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
        ram[12'h200] = 8'h80; ram[12'h201] = 8'h11; ram[12'h202] = 8'h22; ram[12'h203] = 8'h33;
        tick(); tick();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_if_done", {31'd0, if_done}, 32'd0);
        chk("rst_ls_done", {31'd0, ls_done}, 32'd0);
        chk("rst_ld_val", ld_val, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        rst_in = 1'b0;
        tick();

        // instruction fetch of a word
        if_req = 1'b1; if_addr = 32'h100;
        tick(); chk("f_a0", mem_a, 32'h100); chk("f_wr", {31'd0, mem_wr}, 32'd0);
        tick(); chk("f_a1", mem_a, 32'h101);
        tick(); chk("f_a2", mem_a, 32'h102);
        tick(); chk("f_a3", mem_a, 32'h103);
        wait_done(1'b1, n);
        chk("f_lat", n, 32'd2);
        chk("f_data", if_data, 32'h00000513);
        chk("f_ls_done", {31'd0, ls_done}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("f_pulse", {31'd0, if_done}, 32'd0);
        chk("f_hold", if_data, 32'h00000513);

        // signed and unsigned byte loads
        ls_req = 1'b1; ls_r_nw = 1'b1; ls_type = 3'b110; ls_addr = 32'h200;
        wait_done(1'b0, n);
        chk("lb_lat", n, 32'd3);
        chk("lb_val", ld_val, 32'hFFFFFF80);
        chk("lb_if_done", {31'd0, if_done}, 32'd0);
        ls_req = 1'b0; tick();
        ls_req = 1'b1; ls_type = 3'b010;
        wait_done(1'b0, n);
        chk("lbu_lat", n, 32'd3);
        chk("lbu_val", ld_val, 32'h00000080);
        ls_req = 1'b0; tick();

        // halfword store
        wr_n = 0;
        ls_req = 1'b1; ls_r_nw = 1'b0; ls_type = 3'b001; ls_addr = 32'h1FE; st_val = 32'hDEADBEEF;
        wait_done(1'b0, n);
        chk("sh_lat", n, 32'd3);
        chk("sh_ld_val", ld_val, 32'd0);
        ls_req = 1'b0;
        tick(); tick(); tick();
        chk("sh_count", wr_n, 32'd2);
        chk("sh_a0", wr_a[0], 32'h1FE);
        chk("sh_d0", {24'd0, wr_d[0]}, 32'hEF);
        chk("sh_a1", wr_a[1], 32'h1FF);
        chk("sh_d1", {24'd0, wr_d[1]}, 32'hBE);

        // contention from reset: LS first, then IF
        rst_in = 1'b1; tick(); rst_in = 1'b0; tick();
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_r_nw = 1'b1; ls_type = 3'b000; ls_addr = 32'h200;
        tick(); chk("c_first", mem_a, 32'h200);
        wait_done(1'b0, n);
        chk("c_ls_lat", n, 32'd5);
        chk("c_ls_val", ld_val, 32'h33221180);
        chk("c_if_quiet", {31'd0, if_done}, 32'd0);
        tick(); chk("c_nogrant", mem_a, 32'd0);
        tick(); chk("c_second", mem_a, 32'h100);
        ls_req = 1'b0;
        wait_done(1'b1, n);
        chk("c_if_lat", n, 32'd5);
        chk("c_if_data", if_data, 32'h00000513);
        if_req = 1'b0; tick();

        // store to I/O space while the buffer is full
        wr_n = 0; io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_r_nw = 1'b0; ls_type = 3'b010; ls_addr = 32'h30000; st_val = 32'h000000A5;
        tick(); chk("io_stall0", {31'd0, mem_wr}, 32'd0); chk("io_addr", mem_a, 32'h30000);
        tick(); chk("io_stall1", {31'd0, mem_wr}, 32'd0);
        tick(); chk("io_stall2", {31'd0, mem_wr}, 32'd0);
        tick(); io_buffer_full = 1'b0; #1;
        chk("io_go", {31'd0, mem_wr}, 32'd1);
        chk("io_dout", {24'd0, mem_dout}, 32'hA5);
        wait_done(1'b0, n);
        chk("io_lat", n, 32'd1);
        chk("io_count", wr_n, 32'd1);
        ls_req = 1'b0; tick();

        // flush kills an in-flight fetch and blocks a new fetch grant
        if_req = 1'b1; if_addr = 32'h100;
        tick(); tick();
        flush = 1'b1;
        tick(); chk("fl_idle", mem_a, 32'd0); chk("fl_no_done", {31'd0, if_done}, 32'd0);
        tick(); chk("fl_block", mem_a, 32'd0); chk("fl_no_done2", {31'd0, if_done}, 32'd0);
        flush = 1'b0; if_req = 1'b0; tick();

        // rdy_in low pauses a store
        ls_req = 1'b1; ls_r_nw = 1'b0; ls_type = 3'b010; ls_addr = 32'h10; st_val = 32'h5A;
        tick(); rdy_in = 1'b0; #1;
        chk("rdy_wr_off", {31'd0, mem_wr}, 32'd0);
        tick(); chk("rdy_frozen", mem_a, 32'h10); chk("rdy_wr_off2", {31'd0, mem_wr}, 32'd0);
        rdy_in = 1'b1; #1;
        chk("rdy_wr_on", {31'd0, mem_wr}, 32'd1);
        wait_done(1'b0, n);
        chk("rdy_lat", n, 32'd1);
        ls_req = 1'b0; tick();

        // async reset in the middle of a word store
        wr_n = 0;
        ls_req = 1'b1; ls_r_nw = 1'b0; ls_type = 3'b000; ls_addr = 32'h40; st_val = 32'h11223344;
        tick(); tick(); tick();
        chk("ar_pre_wr", {31'd0, mem_wr}, 32'd1);
        chk("ar_pre_a", mem_a, 32'h42);
        #3; rst_in = 1'b1; #1;
        chk("ar_wr", {31'd0, mem_wr}, 32'd0);
        chk("ar_a", mem_a, 32'd0);
        chk("ar_dout", {24'd0, mem_dout}, 32'd0);
        chk("ar_ls_done", {31'd0, ls_done}, 32'd0);
        chk("ar_if_data", if_data, 32'd0);
        chk("ar_ld_val", ld_val, 32'd0);
        ls_req = 1'b0;
        tick(); tick(); rst_in = 1'b0; tick(); tick();
        chk("ar_count", wr_n, 32'd2);
        chk("ar_ram", {24'd0, ram[12'h42]}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
